// File: rtl/dadda_pkg.sv
// ----------------------------------------------------------------------------
// dadda_pkg
// Shared constants for the Dadda multiply-accumulate stage:
//   MUL_W      operand width of the dadda_32 multiplier
//   PROD_W     full product width
//   ACC_W_DEF  default accumulator width (must be >= PROD_W)
//   CNT_W_DEF  default beat-counter width
//   ST_*       FSM state encodings (plain 2-bit constants for legacy tools)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package dadda_pkg;

    localparam int MUL_W     = 32;
    localparam int PROD_W    = 2 * MUL_W;
    localparam int ACC_W_DEF = 72;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/dadda_32.sv
// ----------------------------------------------------------------------------
// dadda_32
// Combinational 32x32 unsigned multiplier. The partial-product reduction tree
// is expressed behaviourally so synthesis can map it onto its own Dadda/
// Wallace style compressor tree.
// Ports:
//   A  in   32  unsigned multiplicand
//   B  in   32  unsigned multiplier
//   Y  out  64  full product A*B
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module dadda_32
    import dadda_pkg::*;
(
    input  logic [MUL_W-1:0]  A,
    input  logic [MUL_W-1:0]  B,
    output logic [PROD_W-1:0] Y
);

    assign Y = {{MUL_W{1'b0}}, A} * {{MUL_W{1'b0}}, B};

endmodule

// File: rtl/dadda_mac_stage.sv
// ----------------------------------------------------------------------------
// dadda_mac_stage
// Sequential multiply-accumulate stage around dadda_32. Operand beats arrive on
// a valid/ready stream, pass through an operand register (S1), the multiplier,
// a product register (S2) and are summed into a wide accumulator. A burst ends
// with in_last; its sum, beat count and overflow flag are then held on a
// valid/ready output until consumed.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       operand beat handshake
//   in_a, in_b              unsigned operands (W bits)
//   in_last                 beat ends the burst
//   acc_clr                 synchronous clear of accumulator and pipeline
//   out_valid/out_ready     burst result handshake
//   out_acc                 accumulated sum of products (ACC_W bits)
//   out_count               beats in the burst, saturating (CNT_W bits)
//   out_ovf                 sticky accumulator carry-out flag
// Configuration macro:
//   SATURATE_EN  defined: accumulator clamps to all-ones after a carry-out.
//                undefined: accumulator wraps modulo 2^ACC_W.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module dadda_mac_stage
    import dadda_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    logic [1:0]        state_q, state_d;
    logic              init_q, init_d;
    logic [W-1:0]      a1_q, a1_d, b1_q, b1_d;
    logic              v1_q, v1_d, last1_q, last1_d;
    logic [PROD_W-1:0] prod_w;
    logic [PROD_W-1:0] prod2_q, prod2_d;
    logic              v2_q, v2_d, last2_q, last2_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              clr_active;
    logic [ACC_W:0]    sum_ext;
    logic              carry;

    dadda_32 u_mul (
        .A (a1_q),
        .B (b1_q),
        .Y (prod_w)
    );

    // init_q keeps in_ready low for the first cycle after reset release.
    assign in_ready   = init_q && (state_q == ST_ACCUM) && !acc_clr;
    assign accept     = in_valid && in_ready;
    assign clr_active = acc_clr && (state_q != ST_HOLD);

    // One extra bit on the add exposes the carry-out for the sticky flag.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod2_q};
    assign carry   = sum_ext[ACC_W];

    assign out_valid = (state_q == ST_HOLD);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        init_d  = 1'b1;
        a1_d    = a1_q;
        b1_d    = b1_q;
        prod2_d = prod2_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        v1_d    = accept;
        last1_d = accept && in_last;
        if (accept) begin
            a1_d = in_a;
            b1_d = in_b;
        end

        v2_d    = v1_q;
        last2_d = v1_q && last1_q;
        if (v1_q) begin
            prod2_d = prod_w;
        end

        if (v2_q) begin
`ifdef SATURATE_EN
            // Once saturated the accumulator stays pinned until cleared.
            acc_d = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            ovf_d = ovf_q || carry;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end

        case (state_q)
            ST_ACCUM: if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (v2_q && last2_q)   state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        // A clear discards the partial burst including beats still in flight.
        if (clr_active) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            v1_d    = 1'b0;
            last1_d = 1'b0;
            v2_d    = 1'b0;
            last2_d = 1'b0;
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            init_q  <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            prod2_q <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            prod2_q <= prod2_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dadda_mac_stage.sv
// ----------------------------------------------------------------------------
// tb_dadda_mac_stage
// Drives two instances (ACC_W=72 and ACC_W=64) with the same beat stream. The
// reference model keeps the exact 128-bit sum of products; expected results
// for each width are derived from it when a burst's last beat is accepted and
// queued for the monitor, which compares whenever out_valid is presented.
// Honours SATURATE_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dadda_mac_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready;

    logic        in_ready72, out_valid72, out_ovf72;
    logic [71:0] out_acc72;
    logic [7:0]  out_count72;
    logic        in_ready64, out_valid64, out_ovf64;
    logic [63:0] out_acc64;
    logic [7:0]  out_count64;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [71:0] acc72;
        logic        ovf72;
        logic [63:0] acc64;
        logic        ovf64;
        logic [7:0]  count;
        int          acceptCyc;
        int          stall;
    } exp_t;

    exp_t        expQ[$];
    logic [127:0] refSum = '0;
    int           refCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dadda_mac_stage #(.ACC_W(72)) u_dut72 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready72),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .acc_clr   (acc_clr),
        .out_valid (out_valid72),
        .out_ready (out_ready),
        .out_acc   (out_acc72),
        .out_count (out_count72),
        .out_ovf   (out_ovf72)
    );

    dadda_mac_stage #(.ACC_W(64)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .acc_clr   (acc_clr),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_acc   (out_acc64),
        .out_count (out_count64),
        .out_ovf   (out_ovf64)
    );

    // Single comparison point: every check bumps total, every miss bumps bad.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected burst result for both widths from the exact running sum.
    function automatic exp_t makeExp(input int acceptCyc, input int stall);
        exp_t e;
        e.ovf72 = |refSum[127:72];
        e.ovf64 = |refSum[127:64];
`ifdef SATURATE_EN
        e.acc72 = e.ovf72 ? {72{1'b1}} : refSum[71:0];
        e.acc64 = e.ovf64 ? {64{1'b1}} : refSum[63:0];
`else
        e.acc72 = refSum[71:0];
        e.acc64 = refSum[63:0];
`endif
        e.count     = (refCount > 255) ? 8'hFF : refCount[7:0];
        e.acceptCyc = acceptCyc;
        e.stall     = stall;
        return e;
    endfunction

    // Offer one beat (after up to idleMax random idle cycles) until accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit last,
                                 input int idleMax, input int stall);
        bit done = 0;
        int acceptCyc = 0;
        if (idleMax > 0) begin
            repeat ($urandom_range(idleMax, 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready72 && in_ready64) begin
                done      = 1;
                acceptCyc = cyc + 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL beat_accept: got no in_ready expected in_ready within 50 cycles");
        end else begin
            refSum   = refSum + 128'(a) * 128'(b);
            refCount = refCount + 1;
            if (last) begin
                expQ.push_back(makeExp(acceptCyc, stall));
                refSum   = '0;
                refCount = 0;
            end
        end
    endtask

    // Bounded wait for all queued results to be consumed.
    task automatic waitIdle();
        bit idle = 0;
        for (int k = 0; k < 100 && !idle; k++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !out_valid72 && !out_valid64) idle = 1;
        end
        if (!idle) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0 within 100 cycles", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: owns out_ready, pops and compares whenever out_valid shows up.
    initial begin
        exp_t e;
        bit seen = 0;
        bit afterFire = 0;
        int stallLeft = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 0;
                afterFire = 0;
                out_ready = 1'b0;
                continue;
            end
            out_ready = 1'b0;
            if (afterFire) begin
                checkOutput("in_ready_after_hs", in_ready72, 1);
                checkOutput("out_valid_after_hs", out_valid72, 0);
                afterFire = 0;
            end
            if (out_valid72 || out_valid64) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    e = expQ[0];
                    if (!seen) begin
                        seen      = 1;
                        stallLeft = e.stall;
                        checkOutput("latency", 128'(cyc), 128'(e.acceptCyc + 2));
                    end
                    checkOutput("out_valid64", out_valid64, 1);
                    checkOutput("out_valid72", out_valid72, 1);
                    checkOutput("out_acc72", out_acc72, e.acc72);
                    checkOutput("out_acc64", out_acc64, e.acc64);
                    checkOutput("out_count72", out_count72, e.count);
                    checkOutput("out_count64", out_count64, e.count);
                    checkOutput("out_ovf72", out_ovf72, e.ovf72);
                    checkOutput("out_ovf64", out_ovf64, e.ovf64);
                    checkOutput("in_ready_hold", in_ready72 | in_ready64, 0);
                    if (stallLeft == 0) begin
                        out_ready = 1'b1;
                        void'(expQ.pop_front());
                        seen      = 0;
                        afterFire = 1;
                    end else begin
                        stallLeft--;
                    end
                end
            end
        end
    end

    initial begin
        // Reset state and first-cycle in_ready behaviour.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid72, 0);
        checkOutput("rst_in_ready", in_ready72, 0);
        checkOutput("rst_out_acc", out_acc72, 0);
        checkOutput("rst_out_count", out_count72, 0);
        checkOutput("rst_out_ovf", out_ovf72, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", in_ready72, 0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_first_cycle", in_ready72, 1);

        // Small burst, consumed immediately.
        applyStimulus(32'd3, 32'd5, 0, 0, 0);
        applyStimulus(32'd7, 32'd11, 1, 0, 0);
        waitIdle();

        // Same burst, consumer stalls for 5 cycles.
        applyStimulus(32'd3, 32'd5, 0, 0, 5);
        applyStimulus(32'd7, 32'd11, 1, 0, 5);
        waitIdle();

        // Max operands: the 64-bit accumulator carries out.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1);
        waitIdle();

        // 15 random beats with random idle gaps.
        for (int i = 0; i < 15; i++) begin
            applyStimulus($urandom, $urandom, (i == 14), 2, 0);
        end
        waitIdle();

        // Clear mid-burst while a beat is offered: that beat must be dropped.
        applyStimulus(32'd2, 32'd2, 0, 0, 0);
        applyStimulus(32'd4, 32'd4, 0, 0, 0);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'd9;
        in_b     = 32'd9;
        @(negedge clk);
        checkOutput("in_ready_during_clr", in_ready72 | in_ready64, 0);
        @(posedge clk);
        #1;
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        refSum   = '0;
        refCount = 0;
        applyStimulus(32'd1, 32'd1, 1, 0, 0);
        waitIdle();

        // Asynchronous reset mid-burst: partial burst vanishes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, $urandom, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_count", out_count72, 0);
        checkOutput("midrst_out_acc", out_acc72, 0);
        checkOutput("midrst_out_valid", out_valid72, 0);
        #1;
        rst_n    = 1'b1;
        refSum   = '0;
        refCount = 0;
        applyStimulus(32'd6, 32'd7, 1, 0, 0);
        waitIdle();

        // Long burst: beat counter saturates, accumulator keeps going.
        for (int i = 0; i < 260; i++) begin
            applyStimulus(32'd1, 32'd1, (i == 259), 0, 0);
        end
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
